tff_counter: RTL and testbench



---
 rtl/tff_pkg.sv | 20 ++
 rtl/tff_stage.sv | 24 ++
 rtl/tff_counter.sv | 96 +++++++++
 tb/tb_tff_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-flop counter family: direction encoding
// and the load clamp rule, kept here so every instance and any model of the
// counter agree on the same clamp behaviour.
package tff_pkg;

  // Direction encoding on up_dn.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest supported counter width.
  localparam int unsigned MAX_WIDTH = 16;

  // A loaded value that falls outside the count sequence is pinned to the
  // last legal state, so the counter can never leave 0..modulus-1.
  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned modulus);
    return (val < modulus) ? val : (modulus - 1);
  endfunction

endpackage

// File: rtl/tff_stage.sv
// Single toggle flop: Q flips on each rising clk edge where in_T is high.
// Port names follow the legacy single-bit toggle flop it replaces.
module tff_stage (
  input  logic clk,
  input  logic reset,
  input  logic in_T,
  output logic Q,
  output logic QBar
);

  // Toggle state, cleared asynchronously while reset is low.
  // NOTE: flop state is written with <= so every stage samples its inputs
  // before any stage updates, regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= 1'b0;
    end else if (in_T) begin
      Q <= ~Q;
    end
  end

  assign QBar = ~Q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH toggle-flop stages.
// Load has priority over counting; tc is combinational so it can drive the
// en of a downstream stage in the same cycle; wrap is a registered pulse in
// the cycle after the count passes the end of its sequence.
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             tc,
  output logic             wrap
);

  // Reject parameter combinations that cannot form a valid sequence.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("tff_counter: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_zero;
  logic             wrap_next;

  assign at_max  = (count == MAX_CNT);
  assign at_zero = (count == '0);

  // Explicit wrap at both ends; with MODULUS = 2**WIDTH this coincides with
  // natural binary overflow, so both cases share one path.
  assign count_inc = at_max  ? '0      : count + 1'b1;
  assign count_dec = at_zero ? MAX_CNT : count - 1'b1;

  assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));

  // Next-state selection with load > en > hold priority.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        count_next = count_inc;
        wrap_next  = at_max;
      end else begin
        count_next = count_dec;
        wrap_next  = at_zero;
      end
    end
  end

  // A stage toggles exactly where its current and next bits differ.
  assign toggle = count ^ count_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_stage u_stage (
      .clk  (clk),
      .reset(reset),
      .in_T (toggle[i]),
      .Q    (count[i]),
      .QBar (count_bar[i])
    );
  end

  // One-cycle wrap pulse following the wrapping edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

  // Terminal count: next enabled edge will wrap.
  assign tc = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: four instances (W4/M10, a cascaded W4/M10 high
// digit, W3/M8, W1/M2) checked against a behavioural model via a scoreboard.
module tb_tff_counter;

  logic clk;
  logic reset;

  logic       a_en, a_ud, a_ld;
  logic [3:0] a_lv;
  logic [3:0] a_cnt, a_bar;
  logic       a_tc, a_wrap;

  logic [3:0] h_cnt, h_bar;
  logic       h_tc, h_wrap;

  logic       b_en, b_ud, b_ld;
  logic [2:0] b_lv;
  logic [2:0] b_cnt, b_bar;
  logic       b_tc, b_wrap;

  logic       c_en, c_ud, c_ld;
  logic [0:0] c_lv;
  logic [0:0] c_cnt, c_bar;
  logic       c_tc, c_wrap;

  tff_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .up_dn(a_ud), .load(a_ld),
    .load_val(a_lv), .count(a_cnt), .count_bar(a_bar), .tc(a_tc), .wrap(a_wrap)
  );

  tff_counter #(.WIDTH(4), .MODULUS(10)) u_h (
    .clk(clk), .reset(reset), .en(a_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(4'd0), .count(h_cnt), .count_bar(h_bar), .tc(h_tc), .wrap(h_wrap)
  );

  tff_counter #(.WIDTH(3), .MODULUS(8)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .up_dn(b_ud), .load(b_ld),
    .load_val(b_lv), .count(b_cnt), .count_bar(b_bar), .tc(b_tc), .wrap(b_wrap)
  );

  tff_counter #(.WIDTH(1), .MODULUS(2)) u_c (
    .clk(clk), .reset(reset), .en(c_en), .up_dn(c_ud), .load(c_ld),
    .load_val(c_lv), .count(c_cnt), .count_bar(c_bar), .tc(c_tc), .wrap(c_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model, one slot per instance: 0=a, 1=h, 2=b, 3=c.
  int mod_of [4] = '{10, 10, 8, 2};
  int w_of   [4] = '{4, 4, 3, 1};
  int m_cnt  [4];
  bit m_wrap [4];

  typedef struct {
    int id;
    int cnt;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];

  function automatic bit model_tc(input int id, input bit en, input bit ld,
                                  input bit ud);
    return en && !ld && ((ud && m_cnt[id] == mod_of[id] - 1) ||
                         (!ud && m_cnt[id] == 0));
  endfunction

  task automatic model_step(input int id, input bit en, input bit ld,
                            input bit ud, input int lv);
    int m;
    m = mod_of[id];
    if (ld) begin
      m_cnt[id]  = (lv < m) ? lv : m - 1;
      m_wrap[id] = 1'b0;
    end else if (en && ud) begin
      m_wrap[id] = (m_cnt[id] == m - 1);
      m_cnt[id]  = (m_cnt[id] + 1) % m;
    end else if (en) begin
      m_wrap[id] = (m_cnt[id] == 0);
      m_cnt[id]  = (m_cnt[id] + m - 1) % m;
    end else begin
      m_wrap[id] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int id);
    case (id)
      0:       return 32'(a_cnt);
      1:       return 32'(h_cnt);
      2:       return 32'(b_cnt);
      default: return 32'(c_cnt);
    endcase
  endfunction

  function automatic logic [31:0] dut_bar(input int id);
    case (id)
      0:       return 32'(a_bar);
      1:       return 32'(h_bar);
      2:       return 32'(b_bar);
      default: return 32'(c_bar);
    endcase
  endfunction

  function automatic logic [31:0] dut_wrap(input int id);
    case (id)
      0:       return 32'(a_wrap);
      1:       return 32'(h_wrap);
      2:       return 32'(b_wrap);
      default: return 32'(c_wrap);
    endcase
  endfunction

  function automatic int bar_of(input int id, input int cnt);
    return (~cnt) & ((1 << w_of[id]) - 1);
  endfunction

  // Check combinational tc, push expected post-edge state, take one edge,
  // then drain the scoreboard against the registered outputs.
  task automatic step();
    exp_t e;
    bit   tc_a;
    #1;
    tc_a = model_tc(0, a_en, a_ld, a_ud);
    check("a_tc", 32'(a_tc), 32'(tc_a));
    check("h_tc", 32'(h_tc), 32'(model_tc(1, tc_a, 1'b0, 1'b1)));
    check("b_tc", 32'(b_tc), 32'(model_tc(2, b_en, b_ld, b_ud)));
    check("c_tc", 32'(c_tc), 32'(model_tc(3, c_en, c_ld, c_ud)));
    if (reset) begin
      model_step(1, tc_a, 1'b0, 1'b1, 0);
      model_step(0, a_en, a_ld, a_ud, int'(a_lv));
      model_step(2, b_en, b_ld, b_ud, int'(b_lv));
      model_step(3, c_en, c_ld, c_ud, int'(c_lv));
    end
    for (int i = 0; i < 4; i++) begin
      e.id   = i;
      e.cnt  = m_cnt[i];
      e.wrap = m_wrap[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("count%0d", e.id), dut_cnt(e.id), 32'(e.cnt));
      check($sformatf("count_bar%0d", e.id), dut_bar(e.id),
            32'(bar_of(e.id, e.cnt)));
      check($sformatf("wrap%0d", e.id), dut_wrap(e.id), 32'(e.wrap));
    end
  endtask

  // Assert reset between edges and check the clear is immediate.
  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_count%0d", i), dut_cnt(i), 32'd0);
      check($sformatf("rst_bar%0d", i), dut_bar(i), 32'(bar_of(i, 0)));
      check($sformatf("rst_wrap%0d", i), dut_wrap(i), 32'd0);
    end
    #1;
    reset = 1'b1;
  endtask

  int wraps;

  initial begin
    reset = 1'b0;
    a_en = 1'b1; a_ud = 1'b0; a_ld = 1'b0; a_lv = 4'd0;
    b_en = 1'b0; b_ud = 1'b1; b_ld = 1'b0; b_lv = 3'd0;
    c_en = 1'b0; c_ud = 1'b1; c_ld = 1'b0; c_lv = 1'b0;
    model_reset();

    // Reset state, and tc evaluated from it while reset is held.
    #2;
    check("init_count", 32'(a_cnt), 32'd0);
    check("init_count_bar", 32'(a_bar), 32'hF);
    check("init_wrap", 32'(a_wrap), 32'd0);
    check("init_tc_down", 32'(a_tc), 32'd1);
    #4;
    reset = 1'b1;
    a_en = 1'b0;

    // Run to 7, then reset mid-run.
    a_ld = 1'b1; a_lv = 4'd7;
    step();
    a_ld = 1'b0;
    step();
    check("pre_reset_count", 32'(a_cnt), 32'd7);
    reset_pulse();

    // Count up 12 edges: 1..9,0,1,2.
    a_en = 1'b1; a_ud = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("up_end", 32'(a_cnt), 32'd2);

    // Count down from 2: 2,1,0,9,8.
    a_ld = 1'b1; a_lv = 4'd2;
    step();
    a_ld = 1'b0; a_ud = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("down_end", 32'(a_cnt), 32'd8);

    // Load clamp with load over en, then wrap from the clamped value.
    a_ld = 1'b1; a_en = 1'b1; a_ud = 1'b1; a_lv = 4'd13;
    step();
    check("clamp_count", 32'(a_cnt), 32'd9);
    a_ld = 1'b0;
    step();
    check("clamp_wrap", 32'(a_wrap), 32'd1);

    // Cascade: 100 low edges walk 00..99 back to 00.
    reset_pulse();
    a_en = 1'b1; a_ud = 1'b1;
    wraps = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (a_wrap) wraps++;
    end
    check("cascade_wraps", 32'(wraps), 32'd10);
    check("cascade_hi", 32'(h_cnt), 32'd0);
    a_en = 1'b0;

    // Full binary wrap, hold, and mid-count direction flip.
    b_ld = 1'b1; b_lv = 3'd7;
    step();
    b_ld = 1'b0; b_en = 1'b1; b_ud = 1'b1;
    step();
    check("bin_wrap_count", 32'(b_cnt), 32'd0);
    check("bin_wrap", 32'(b_wrap), 32'd1);
    b_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    b_ld = 1'b1; b_lv = 3'd4;
    step();
    b_ld = 1'b0; b_en = 1'b1;
    step();
    b_ud = 1'b0;
    step();
    check("flip_count", 32'(b_cnt), 32'd4);
    b_en = 1'b0;

    // Minimum modulus: back-to-back alternate-cycle wraps.
    c_en = 1'b1; c_ud = 1'b1;
    for (int i = 0; i < 8; i++) step();
    c_ud = 1'b0;
    for (int i = 0; i < 4; i++) step();
    c_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
